tile_access_client: RTL
=======================

Name: tile_access_client

Overview:
Initiator for the nibble-addressed tile memory port (write_en / clean_mark / address / data_in / data_out / ready) that sits in front of the SRAM controller.
- Game logic issues single tile requests over a valid/ready channel: read, write or clean.
- This block sequences the tile port's pulse-and-wait protocol, captures read data, enforces a ready timeout and returns one response per request.

Parameters:
DEPTH, 19, SRAM word-address MSB index; tile address width is DEPTH+3.
ADDR_W, DEPTH+3, tile (nibble) address width (22 at default).
READ_WAIT, 2, cycles the address is held before sampling tile_data_out on a read (1..15).
TIMEOUT, 1023, max cycles spent in WAIT_READY plus DRAIN before aborting with error.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE.
req_op  in  2  00 read, 01 write, 10 clean, 11 reserved.
req_addr  in  ADDR_W  nibble address; [1:0] selects the nibble within the 16-bit word.
req_data  in  4  write nibble.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed.
rsp_data  out  4  read nibble; 0 for write, clean and error responses.
rsp_err  out  1  timeout or reserved op.
busy  out  1  state != IDLE.
tile_write_en  out  1  one-cycle write pulse.
tile_clean_mark  out  1  one-cycle clean pulse.
tile_address  out  ADDR_W  registered, held stable for the whole operation.
tile_data_in  out  4  registered write nibble.
tile_data_out  in  4  nibble from the tile port.
tile_ready  in  1  completion; asserted for exactly 2 consecutive cycles per write/clean.

Behaviour:
- Reset state: state=IDLE; all outputs 0 except req_ready=1; counters 0.
- States: IDLE, ISSUE, WAIT_READY, DRAIN, READ_WAIT, RESP.
- IDLE, on req_valid&&req_ready, latch op, addr and data into registers:
  - op 01 (write) or 10 (clean) -> ISSUE.
  - op 00 (read) -> READ_WAIT.
  - op 11 (reserved) -> RESP with rsp_err=1; no tile activity.
- ISSUE (1 cycle):
  - tile_write_en=1 for write, tile_clean_mark=1 for clean; never both.
  - Clear the timeout counter; go to WAIT_READY.
- WAIT_READY:
  - tile_ready=1 -> DRAIN.
  - Otherwise increment the counter; at count==TIMEOUT -> RESP with rsp_err=1.
- DRAIN:
  - Stay while tile_ready=1; on tile_ready=0 -> RESP with rsp_err=0.
  - The same counter continues; TIMEOUT here also -> RESP with rsp_err=1.
  - DRAIN guarantees the tile port is back in its idle state before the next pulse.
- READ_WAIT:
  - Counter runs 1..READ_WAIT.
  - On the cycle the count equals READ_WAIT, register rsp_data<=tile_data_out and go to RESP.
- RESP: rsp_valid=1, with rsp_data and rsp_err held stable until rsp_ready=1; then -> IDLE.
- Only one request is outstanding; req_ready=0 from accept until return to IDLE.
- Latency, no backpressure, tile_ready rising k cycles after the pulse:
  - Write/clean: accept at cycle N; pulse at N+1; first tile_ready at N+1+k; rsp_valid at N+k+4.
  - Read: rsp_valid at N+READ_WAIT+1.
  - Reserved op: rsp_valid at N+1.
- Boundaries:
  - tile_ready seen outside WAIT_READY/DRAIN (stale or spurious) is ignored.
  - tile_address and tile_data_in change only on accept.
  - Reset mid-operation aborts immediately with no response; the tile port shares this reset.
  - Address wrap is the caller's concern; addr is passed through unmodified.
  - Back-to-back requests: req_valid held high is accepted on the first IDLE cycle after RESP completes.

Decomposition:
- Package tile_pkg holds:
  - Op encodings: OP_READ=2'b00, OP_WRITE=2'b01, OP_CLEAN=2'b10, OP_RSVD=2'b11.
  - State enumeration.
  - Default DEPTH constant.
- Single module; no sub-module. The timeout/read-wait counter is shared, width clog2(TIMEOUT+1).

Test Plan:
- Write: op=01, addr=22'h000005, data=4'hA; tile model raises ready 3 cycles after the pulse for 2 cycles.
  - Expect exactly one write_en pulse with tile_address=5 and tile_data_in=A.
  - rsp_valid at N+7, rsp_err=0, rsp_data=0.
- Read: op=00, addr=22'h000006, tile_data_out=4'h7, READ_WAIT=2.
  - Expect no write_en or clean_mark pulse.
  - rsp_data=7 with rsp_valid at N+3.
- Clean: op=10.
  - Expect one clean_mark pulse, write_en stays 0.
  - Response after ready deasserts, rsp_err=0.
- Timeout: op=01 with tile_ready held 0, TIMEOUT=15.
  - Expect rsp_err=1 after 15 WAIT_READY cycles; req_ready returns only after the response is consumed.
- Reserved op and backpressure: op=11 with rsp_ready low for 5 cycles.
  - Expect rsp_valid and rsp_err held for 5 cycles, no tile pulses, then IDLE.
- Reset mid-op: assert reset during WAIT_READY.
  - Next cycle all outputs 0, req_ready=1, no response emitted.
  - A subsequent write completes normally.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared encodings for the tile memory port initiator: request opcodes,
// FSM state constants and the default SRAM depth.
package tile_pkg;

    localparam int DEFAULT_DEPTH = 19;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAN = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_WAIT_READY = 3'd2;
    localparam logic [2:0] ST_DRAIN      = 3'd3;
    localparam logic [2:0] ST_READ_WAIT  = 3'd4;
    localparam logic [2:0] ST_RESP       = 3'd5;

endpackage

// File: rtl/tile_access_client.sv
// Single-request initiator for the nibble-addressed tile port: pulses
// write/clean, waits out tile_ready with a timeout, samples reads, returns one response.
//
// Handshakes: a request transfers on the rising clk edge where req_valid and
// req_ready are both high; a response transfers where rsp_valid and rsp_ready
// are both high. rsp_valid, rsp_data and rsp_err stay stable until that edge.
module tile_access_client
    import tile_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_W    = DEPTH + 3,
    parameter int READ_WAIT = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [3:0]        rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              tile_write_en,
    output logic              tile_clean_mark,
    output logic [ADDR_W-1:0] tile_address,
    output logic [3:0]        tile_data_in,
    input  logic [3:0]        tile_data_out,
    input  logic              tile_ready,
    output logic [2:0]        dbg_state
);

    // Shared counter must also hold READ_WAIT (up to 15) when TIMEOUT is tiny.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RW_CNT   = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;

    assign req_ready       = (state == ST_IDLE);
    assign busy            = (state != ST_IDLE);
    assign rsp_valid       = (state == ST_RESP);
    assign tile_write_en   = (state == ST_ISSUE) && (op_q == OP_WRITE);
    assign tile_clean_mark = (state == ST_ISSUE) && (op_q == OP_CLEAN);
    assign dbg_state       = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_q         <= OP_READ;
            cnt          <= '0;
            rsp_data     <= 4'h0;
            rsp_err      <= 1'b0;
            tile_address <= '0;
            tile_data_in <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q         <= req_op;
                        tile_address <= req_addr;
                        tile_data_in <= req_data;
                        rsp_data     <= 4'h0;
                        cnt          <= CNT_ONE;
                        if (req_op == OP_RSVD) begin
                            rsp_err <= 1'b1;
                            state   <= ST_RESP;
                        end else begin
                            rsp_err <= 1'b0;
                            state   <= (req_op == OP_READ) ? ST_READ_WAIT : ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    // A ready seen here always wins over an expiring timeout.
                    if (tile_ready) begin
                        cnt   <= cnt + CNT_ONE;
                        state <= ST_DRAIN;
                    end else if (cnt >= TO_LAST) begin
                        rsp_err <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (!tile_ready) begin
                        state <= ST_RESP;
                    end else if (cnt >= TO_LAST) begin
                        rsp_err <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_READ_WAIT: begin
                    if (cnt == RW_CNT) begin
                        rsp_data <= tile_data_out;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
